vending_machine_param: RTL and testbench

Parametrised next-generation vending controller. It accepts coins of three configurable denominations, accumulates credit, and vends when credit reaches PRICE. Change is returned as a train of one-unit pulses. On cancel or timeout it refunds the full credit instead of discarding it. It sits between the coin-acceptor decoder and the dispense/payout actuators.

---
 rtl/vending_machine_param.sv | 156 +++++++++++++++
 tb/tb_vending_machine_param.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_param.sv
// Parametrised vending controller: accumulates coin credit, vends at PRICE,
// pays change or refunds as a train of one-unit pulses.
module vending_machine_param #(
  parameter int PRICE     = 3,
  parameter int COIN1_VAL = 1,
  parameter int COIN2_VAL = 2,
  parameter int COIN3_VAL = 5,
  parameter int CREDIT_W  = 4,
  parameter int TIMEOUT   = 15,
  parameter int TO_W      = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic                cancel,
  output logic                product,
  output logic                change_pulse,
  output logic                refund,
  output logic                coin_rej,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_RETURN} state_t;

  localparam int MAX12    = (COIN1_VAL > COIN2_VAL) ? COIN1_VAL : COIN2_VAL;
  localparam int MAX_COIN = (MAX12 > COIN3_VAL) ? MAX12 : COIN3_VAL;

  localparam logic [CREDIT_W:0] PRICE_X = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0] C1_X    = (CREDIT_W+1)'(COIN1_VAL);
  localparam logic [CREDIT_W:0] C2_X    = (CREDIT_W+1)'(COIN2_VAL);
  localparam logic [CREDIT_W:0] C3_X    = (CREDIT_W+1)'(COIN3_VAL);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);

  // Parameter sanity: the largest reachable sum must fit in the credit register
  if (PRICE - 1 + MAX_COIN >= (1 << CREDIT_W)) begin : g_bad_credit_w
    $error("vending_machine_param: PRICE-1+max coin does not fit in CREDIT_W");
  end
  if (TIMEOUT < 1 || TIMEOUT >= (1 << TO_W)) begin : g_bad_timeout
    $error("vending_machine_param: TIMEOUT must be >=1 and fit in TO_W");
  end

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] remaining_q, remaining_d;
  logic [TO_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic                refund_q, refund_d;
  logic                coin_rej_q, coin_rej_d;

  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   sum;
  logic                coin_in;
  logic                sum_ovf;
  logic                sum_vend;

  // Coin decode and credit arithmetic at CREDIT_W+1 bits
  always_comb begin
    coin_val = '0;
    case (coin)
      2'b01:   coin_val = C1_X;
      2'b10:   coin_val = C2_X;
      2'b11:   coin_val = C3_X;
      default: coin_val = '0;
    endcase
    coin_in  = (coin != 2'b00);
    sum      = {1'b0, credit_q} + coin_val;
    sum_ovf  = sum[CREDIT_W];
    sum_vend = (sum >= PRICE_X);
  end

  // Next-state and register updates for the controller FSM
  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    remaining_d = remaining_q;
    idle_cnt_d  = idle_cnt_q;
    refund_d    = refund_q;
    coin_rej_d  = 1'b0;
    unique case (state_q)
      S_IDLE, S_COLLECT: begin
        if (state_q == S_COLLECT && cancel) begin
          coin_rej_d  = coin_in;
          remaining_d = credit_q;
          credit_d    = '0;
          refund_d    = 1'b1;
          state_d     = (credit_q != '0) ? S_RETURN : S_IDLE;
        end else if (coin_in) begin
          if (sum_ovf) begin
            coin_rej_d = 1'b1;
          end else if (sum_vend) begin
            remaining_d = CREDIT_W'(sum - PRICE_X);
            credit_d    = '0;
            state_d     = S_VEND;
          end else begin
            credit_d   = sum[CREDIT_W-1:0];
            idle_cnt_d = '0;
            state_d    = S_COLLECT;
          end
        end else if (state_q == S_COLLECT) begin
          if (idle_cnt_q == TO_LAST) begin
            remaining_d = credit_q;
            credit_d    = '0;
            refund_d    = 1'b1;
            state_d     = (credit_q != '0) ? S_RETURN : S_IDLE;
          end else begin
            idle_cnt_d = idle_cnt_q + TO_W'(1);
          end
        end
      end
      S_VEND: begin
        coin_rej_d = coin_in;
        refund_d   = 1'b0;
        state_d    = (remaining_q != '0) ? S_RETURN : S_IDLE;
      end
      S_RETURN: begin
        coin_rej_d  = coin_in;
        remaining_d = remaining_q - CREDIT_W'(1);
        if (remaining_q <= CREDIT_W'(1)) begin
          remaining_d = '0;
          refund_d    = 1'b0;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      credit_q    <= '0;
      remaining_q <= '0;
      idle_cnt_q  <= '0;
      refund_q    <= 1'b0;
      coin_rej_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      remaining_q <= remaining_d;
      idle_cnt_q  <= idle_cnt_d;
      refund_q    <= refund_d;
      coin_rej_q  <= coin_rej_d;
    end
  end

  // Outputs decoded purely from registered state
  always_comb begin
    product      = (state_q == S_VEND);
    change_pulse = (state_q == S_RETURN);
    busy         = (state_q == S_VEND) || (state_q == S_RETURN);
    refund       = refund_q && (state_q == S_RETURN);
    coin_rej     = coin_rej_q;
    credit       = credit_q;
  end

endmodule

// File: tb/tb_vending_machine_param.sv
// Scoreboard bench for vending_machine_param: a transaction-level reference
// model schedules expected output events; a monitor pops and compares them.
module tb_vending_machine_param;

  localparam int PRICE     = 3;
  localparam int COIN1_VAL = 1;
  localparam int COIN2_VAL = 2;
  localparam int COIN3_VAL = 5;
  localparam int CREDIT_W  = 4;
  localparam int TIMEOUT   = 15;
  localparam int TO_W      = 5;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [1:0]          coin = 2'b00;
  logic                cancel = 1'b0;
  logic                product, change_pulse, refund, coin_rej, busy;
  logic [CREDIT_W-1:0] credit;

  vending_machine_param #(
    .PRICE(PRICE), .COIN1_VAL(COIN1_VAL), .COIN2_VAL(COIN2_VAL),
    .COIN3_VAL(COIN3_VAL), .CREDIT_W(CREDIT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk(clk), .reset(reset), .coin(coin), .cancel(cancel),
    .product(product), .change_pulse(change_pulse), .refund(refund),
    .coin_rej(coin_rej), .busy(busy), .credit(credit)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int stamp;
    bit prod;
    bit pulse;
    bit refund;
    bit rej;
  } ev_t;

  ev_t exp_q[$];

  int  n_checks = 0;
  int  n_pass   = 0;
  bit  started  = 0;

  // Reference model state: what the machine holds, not how it is encoded
  int  credit_m    = 0;
  int  busy_left   = 0;
  bit  collecting  = 0;
  int  idle_m      = 0;

  function automatic void check(string name, int got, int expv);
    n_checks++;
    if (got == expv) n_pass++;
    else $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_cnt, got, expv);
  endfunction

  function automatic void add_ev(int stamp, bit prod, bit pulse, bit rf, bit rej);
    ev_t e;
    e.stamp = stamp; e.prod = prod; e.pulse = pulse; e.refund = rf; e.rej = rej;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].stamp == stamp) begin
        exp_q[i].prod   = exp_q[i].prod   | prod;
        exp_q[i].pulse  = exp_q[i].pulse  | pulse;
        exp_q[i].refund = exp_q[i].refund | rf;
        exp_q[i].rej    = exp_q[i].rej    | rej;
        return;
      end
      if (exp_q[i].stamp > stamp) begin
        exp_q.insert(i, e);
        return;
      end
    end
    exp_q.push_back(e);
  endfunction

  function automatic int coin_units(logic [1:0] c);
    case (c)
      2'b01:   return COIN1_VAL;
      2'b10:   return COIN2_VAL;
      2'b11:   return COIN3_VAL;
      default: return 0;
    endcase
  endfunction

  function automatic void give_back(int e, int n, bit rf);
    for (int i = 0; i < n; i++) add_ev(e + 1 + i, 0, 1, rf, 0);
    busy_left  = n;
    credit_m   = 0;
    collecting = 0;
    idle_m     = 0;
  endfunction

  // Apply one cycle of input to the model; e is the number of edges so far
  function automatic void model_step(logic [1:0] c, bit can, bit rst, int e);
    int sum;
    if (rst) begin
      credit_m = 0; busy_left = 0; collecting = 0; idle_m = 0;
      while (exp_q.size() > 0 && exp_q[exp_q.size()-1].stamp > e) void'(exp_q.pop_back());
      return;
    end
    if (busy_left > 0) begin
      if (c != 2'b00) add_ev(e + 1, 0, 0, 0, 1);
      busy_left--;
      return;
    end
    if (collecting && can) begin
      if (c != 2'b00) add_ev(e + 1, 0, 0, 0, 1);
      give_back(e, credit_m, 1);
      return;
    end
    if (c != 2'b00) begin
      sum = credit_m + coin_units(c);
      if (sum >= PRICE) begin
        add_ev(e + 1, 1, 0, 0, 0);
        for (int i = 0; i < sum - PRICE; i++) add_ev(e + 2 + i, 0, 1, 0, 0);
        busy_left  = 1 + sum - PRICE;
        credit_m   = 0;
        collecting = 0;
      end else begin
        credit_m   = sum;
        collecting = 1;
        idle_m     = 0;
      end
      return;
    end
    if (collecting) begin
      idle_m++;
      if (idle_m == TIMEOUT) give_back(e, credit_m, 1);
    end
  endfunction

  task automatic drive(input logic [1:0] c, input bit can, input bit rst);
    @(negedge clk);
    coin   = c;
    cancel = can;
    reset  = rst;
    model_step(c, can, rst, edge_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b00, 0, 0);
  endtask

  // Monitor: compares every cycle after the active edge
  initial begin
    int got_v, exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (!started) continue;
      while (exp_q.size() > 0 && exp_q[0].stamp < edge_cnt) begin
        n_checks++;
        $display("FAIL missed_event stamp %0d at edge %0d: got none expected event", exp_q[0].stamp, edge_cnt);
        void'(exp_q.pop_front());
      end
      got_v = {product, change_pulse, refund, coin_rej, busy};
      exp_v = 0;
      if (exp_q.size() > 0 && exp_q[0].stamp == edge_cnt) begin
        exp_v = {exp_q[0].prod, exp_q[0].pulse, exp_q[0].refund, exp_q[0].rej,
                 exp_q[0].prod | exp_q[0].pulse};
        void'(exp_q.pop_front());
      end
      check("outputs{prod,pulse,refund,rej,busy}", got_v, exp_v);
      check("credit", int'(credit), credit_m);
    end
  end

  initial begin
    int r;
    logic [1:0] rc;
    // Hold reset for two edges, then release with the model cleared
    @(posedge clk);
    drive(2'b00, 0, 1);
    started = 1;
    drive(2'b00, 0, 0);

    // 1: three single-unit coins vend exactly with no change
    drive(2'b01, 0, 0); drive(2'b01, 0, 0); drive(2'b01, 0, 0); idle(3);
    // 2: 2+2 gives one unit of change
    drive(2'b10, 0, 0); drive(2'b10, 0, 0); idle(4);
    // 3: single 5-unit coin vends immediately, two change pulses
    drive(2'b11, 0, 0); idle(4);
    // 4: timeout refund after exactly TIMEOUT coinless cycles
    drive(2'b01, 0, 0); idle(TIMEOUT); idle(3);
    // 4b: coin on the 14th idle cycle restarts the count
    drive(2'b01, 0, 0); idle(TIMEOUT - 2); drive(2'b01, 0, 0); idle(TIMEOUT + 3);
    // 5: cancel with a simultaneous coin rejects the coin and refunds
    drive(2'b10, 0, 0); drive(2'b01, 1, 0); idle(4);
    // cancel in IDLE is ignored
    drive(2'b00, 1, 0); idle(2);
    // 6: reset during the first change pulse abandons the rest
    drive(2'b11, 0, 0); drive(2'b00, 0, 0); drive(2'b00, 0, 1); idle(4);
    // coins during VEND and RETURN are rejected, credit untouched
    drive(2'b11, 0, 0); drive(2'b01, 0, 0); drive(2'b10, 0, 0); idle(4);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      r  = $urandom_range(0, 99);
      rc = 2'($urandom_range(1, 3));
      if (r < 2)       drive(2'b00, 0, 1);
      else if (r < 40) drive(rc, 0, 0);
      else if (r < 46) drive(($urandom_range(0, 1) != 0) ? rc : 2'b00, 1, 0);
      else if (r < 97) drive(2'b00, 0, 0);
      else             idle($urandom_range(TIMEOUT - 3, TIMEOUT + 2));
    end

    idle(25);
    check("pending_events", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
